// File: rtl/dpic_mem_bridge_if.sv
// Request/response bundle for dpic_mem_bridge plus the host-memory hooks (pmem_read/pmem_write) it calls.
// pmem_write and its call counter exist only when DPIC_MEM_WRITE_EN is defined.
interface dpic_mem_bridge_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_len;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wmask;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_last;
    logic              rsp_err;

    // Byte-addressed host memory; unpopulated bytes read as zero.
    logic [7:0]  host_mem [logic [63:0]];
    int unsigned rd_calls;
`ifdef DPIC_MEM_WRITE_EN
    int unsigned wr_calls;
`endif

    function automatic void mem_load(input logic [63:0] addr, input logic [7:0] data);
        host_mem[addr] = data;
    endfunction

    function automatic logic [63:0] pmem_read(input logic [63:0] addr, input int unsigned nbytes);
        logic [63:0] data;
        data = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < nbytes && host_mem.exists(addr + 64'(i)) != 0) begin
                data[8*i +: 8] = host_mem[addr + 64'(i)];
            end
        end
        rd_calls = rd_calls + 1;
        return data;
    endfunction

`ifdef DPIC_MEM_WRITE_EN
    function automatic void pmem_write(input logic [63:0] addr, input logic [63:0] wdata,
                                       input logic [7:0] wmask);
        for (int unsigned i = 0; i < 8; i++) begin
            if (wmask[i]) begin
                host_mem[addr + 64'(i)] = wdata[8*i +: 8];
            end
        end
        wr_calls = wr_calls + 1;
    endfunction
`endif

    modport master (
        output req_valid, req_we, req_addr, req_len, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_len, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
        import pmem_read
`ifdef DPIC_MEM_WRITE_EN
        , import pmem_write
`endif
    );
endinterface

// File: rtl/dpic_mem_bridge.sv
// Single-outstanding request bridge onto host memory: fixed-latency reads (bursts) and writes.
// Define DPIC_MEM_WRITE_EN to enable pmem_write; otherwise writes respond with rsp_err=1.
module dpic_mem_bridge #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             rst,
    dpic_mem_bridge_if.slave bus
);
    localparam int unsigned       STRB_W     = DATA_W / 8;
    localparam int unsigned       LAT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(STRB_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRB_W - 1);
    localparam logic [3:0]        LEN_CAP    = 4'(MAX_BURST - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD   = LAT_W'(LATENCY - 1);
`ifdef DPIC_MEM_WRITE_EN
    localparam logic              WRITE_ERR  = 1'b0;
`else
    localparam logic              WRITE_ERR  = 1'b1;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic              we_q,        we_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [3:0]        left_q,      left_d;
    logic [LAT_W-1:0]  lat_q,       lat_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_last_q,  rsp_last_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rd_call_c;
`ifdef DPIC_MEM_WRITE_EN
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [STRB_W-1:0] wmask_q,     wmask_d;
    logic              wr_call_c;
`endif

    // Next-state, beat sequencing and memory-call enables.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        left_d      = left_q;
        lat_d       = lat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        rd_call_c   = 1'b0;
`ifdef DPIC_MEM_WRITE_EN
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        wr_call_c   = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    state_d = WAIT;
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr & ALIGN_MASK;
                    left_d  = (bus.req_len > LEN_CAP) ? LEN_CAP : bus.req_len;
                    lat_d   = LAT_LOAD;
`ifdef DPIC_MEM_WRITE_EN
                    wdata_d = bus.req_wdata;
                    wmask_d = bus.req_wmask;
`endif
                end
            end
            WAIT: begin
                // First beat is presented on the edge that leaves WAIT.
                if (lat_q == '0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    if (we_q) begin
                        rsp_last_d  = 1'b1;
                        rsp_err_d   = WRITE_ERR;
                        rsp_rdata_d = '0;
`ifdef DPIC_MEM_WRITE_EN
                        wr_call_c   = (wmask_q != '0);
`endif
                    end else begin
                        rd_call_c  = 1'b1;
                        rsp_last_d = (left_q == 4'd0);
                        rsp_err_d  = 1'b0;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    if (rsp_last_q) begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b0;
                        rsp_last_d  = 1'b0;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = '0;
                    end else begin
                        addr_d     = addr_q + STEP;
                        left_d     = left_q - 4'd1;
                        rd_call_c  = 1'b1;
                        rsp_last_d = (left_q == 4'd1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // State/output registers; memory hooks fire on the edge that presents a beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            left_q      <= '0;
            lat_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef DPIC_MEM_WRITE_EN
            wdata_q     <= '0;
            wmask_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            left_q      <= left_d;
            lat_q       <= lat_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            if (rd_call_c) begin
                rsp_rdata_q <= DATA_W'(bus.pmem_read(64'(addr_d), STRB_W));
            end else begin
                rsp_rdata_q <= rsp_rdata_d;
            end
`ifdef DPIC_MEM_WRITE_EN
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            if (wr_call_c) begin
                bus.pmem_write(64'(addr_q), 64'(wdata_q), 8'(wmask_q));
            end
`endif
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dpic_mem_bridge.sv
// Scoreboard bench for dpic_mem_bridge: byte-level reference memory, randomized traffic and directed corners.
module tb_dpic_mem_bridge;
    localparam int unsigned ADDR_W    = 64;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned LATENCY   = 2;
    localparam int unsigned MAX_BURST = 8;
    localparam logic [63:0] BASE      = 64'h0000_0000_8000_0000;
    localparam logic [63:0] TOP       = 64'hFFFF_FFFF_FFFF_FFE0;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        err;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dpic_mem_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dpic_mem_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  ref_mem [logic [63:0]];
    beat_t       exp_q [$];
    int unsigned acc_q [$];
    int unsigned exp_rd_calls = 0;
    int unsigned exp_wr_calls = 0;
    int          pops = 0;
    int          ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        logic [63:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) begin
            if (ref_mem.exists(a + 64'(k)) != 0) d[8*k +: 8] = ref_mem[a + 64'(k)];
        end
        return d;
    endfunction

    // Consumer ready: random, forced high, or forced low.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
            1:       bus.rsp_ready = 1'b1;
            default: bus.rsp_ready = 1'b0;
        endcase
    end

    // Monitor: pops expected beats on handshakes and checks timing and stability.
    bit    hold_v, exp_next, exp_rdy, in_txn;
    beat_t held;
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 0; exp_next = 0; exp_rdy = 0; in_txn = 0;
        end else begin
            if (exp_rdy) begin
                check("req_ready_after_last", 64'(bus.req_ready), 64'd1);
                exp_rdy = 0;
            end
            if (exp_next) begin
                check("next_beat_no_gap", 64'(bus.rsp_valid), 64'd1);
                exp_next = 0;
            end
            if (hold_v) begin
                check("hold_valid", 64'(bus.rsp_valid), 64'd1);
                check("hold_rdata", bus.rsp_rdata, held.data);
                check("hold_last", 64'(bus.rsp_last), 64'(held.last));
                check("hold_err", 64'(bus.rsp_err), 64'(held.err));
                hold_v = 0;
            end
            if (bus.rsp_valid) begin
                check("busy_req_ready", 64'(bus.req_ready), 64'd0);
                if (!in_txn) begin
                    in_txn = 1;
                    if (acc_q.size() == 0) fail_now("unexpected_response");
                    else check("first_beat_latency", 64'(cyc), 64'(acc_q.pop_front() + LATENCY));
                end
                if (bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("rsp_rdata", bus.rsp_rdata, e.data);
                        check("rsp_last", 64'(bus.rsp_last), 64'(e.last));
                        check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    end
                    pops++;
                    if (bus.rsp_last) begin
                        exp_rdy = 1;
                        in_txn  = 0;
                    end else begin
                        exp_next = 1;
                    end
                end else begin
                    hold_v = 1;
                    held.data = bus.rsp_rdata;
                    held.last = bus.rsp_last;
                    held.err  = bus.rsp_err;
                end
            end
        end
    end

    // Issue one request, push its expected beats, then wiggle req_valid while the bridge is busy.
    task automatic issue(input logic we, input logic [63:0] addr, input logic [3:0] len,
                         input logic [63:0] wd, input logic [7:0] wm);
        int          guard;
        int unsigned n;
        logic [63:0] al;
        beat_t       b;
        guard = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_len   = len;
        bus.req_wdata = wd;
        bus.req_wmask = wm;
        while (!bus.req_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            fail_now("req_accept_timeout");
            bus.req_valid = 1'b0;
            return;
        end
        al = addr & ~64'd7;
        acc_q.push_back(cyc + 1);
        if (we) begin
            b.data = '0;
            b.last = 1'b1;
`ifdef DPIC_MEM_WRITE_EN
            b.err = 1'b0;
            if (wm != 8'd0) begin
                exp_wr_calls++;
                for (int k = 0; k < 8; k++) if (wm[k]) ref_mem[al + 64'(k)] = wd[8*k +: 8];
            end
`else
            b.err = 1'b1;
`endif
            exp_q.push_back(b);
        end else begin
            n = ((int'(len) > MAX_BURST - 1) ? MAX_BURST - 1 : int'(len)) + 1;
            for (int unsigned i = 0; i < n; i++) begin
                b.data = ref_read(al + 64'(i * 8));
                b.last = (i == n - 1);
                b.err  = 1'b0;
                exp_q.push_back(b);
            end
            exp_rd_calls += n;
        end
        @(posedge clk);
        #1;
        bus.req_we    = ~we;
        bus.req_addr  = {$urandom, $urandom};
        bus.req_len   = 4'($urandom);
        bus.req_wmask = 8'hFF;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || in_txn) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  bv;
        int          guard;
        int          p0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        for (int i = 0; i < 512; i++) begin
            bv = 8'($urandom);
            bus.mem_load(BASE + 64'(i), bv);
            ref_mem[BASE + 64'(i)] = bv;
        end
        for (int i = 0; i < 32; i++) begin
            bv = 8'($urandom);
            bus.mem_load(TOP + 64'(i), bv);
            ref_mem[TOP + 64'(i)] = bv;
            bv = 8'($urandom);
            bus.mem_load(64'(i), bv);
            ref_mem[64'(i)] = bv;
        end

        repeat (3) @(negedge clk);
        check("reset_req_ready", 64'(bus.req_ready), 64'd0);
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_rsp_last", 64'(bus.rsp_last), 64'd0);
        check("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 64'd0);
        rst = 1'b0;

        // Single unaligned read, then a full-rate burst.
        issue(1'b0, 64'h8000_0004, 4'd0, '0, '0);
        drain();
        ready_mode = 1;
        issue(1'b0, BASE + 64'h40, 4'd3, '0, '0);
        drain();
        // Backpressure on the first beat.
        ready_mode = 2;
        issue(1'b0, BASE + 64'h100, 4'd3, '0, '0);
        guard = 0;
        while (!bus.rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (5) @(negedge clk);
        ready_mode = 1;
        drain();
        ready_mode = 0;
        // Write then read back, masked-out write, wrap and length cap.
        issue(1'b1, BASE + 64'h20, 4'd0, 64'h1122_3344_5566_7788, 8'h0F);
        issue(1'b0, BASE + 64'h20, 4'd0, '0, '0);
        issue(1'b1, BASE + 64'h28, 4'd0, 64'hDEAD_BEEF_CAFE_F00D, 8'h00);
        issue(1'b0, BASE + 64'h28, 4'd0, '0, '0);
        issue(1'b0, TOP + 64'h10, 4'd3, '0, '0);
        issue(1'b0, BASE + 64'h80, 4'd15, '0, '0);
        drain();

        for (int t = 0; t < 40; t++) begin
            logic        we;
            logic [7:0]  wm;
            we = ($urandom_range(0, 3) == 0);
            wm = 8'($urandom);
            if ($urandom_range(0, 4) == 0) wm = 8'd0;
            issue(we, BASE + 64'($urandom_range(0, 440)), 4'($urandom), {$urandom, $urandom}, wm);
        end
        drain();

        // Reset after the second beat of an 8-beat burst.
        ready_mode = 1;
        @(negedge clk);
        p0 = pops;
        issue(1'b0, BASE + 64'h10, 4'd7, '0, '0);
        guard = 0;
        while (pops < p0 + 2 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        check("reset_test_beats_seen", 64'(pops - p0), 64'd2);
        #2 rst = 1'b1;
        #1;
        check("midreset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("midreset_req_ready", 64'(bus.req_ready), 64'd0);
        exp_q.delete();
        acc_q.delete();
        exp_rd_calls -= 5;
        repeat (3) @(negedge clk);
        check("pmem_read_calls_at_reset", 64'(bus.rd_calls), 64'(exp_rd_calls));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("req_ready_after_release", 64'(bus.req_ready), 64'd1);
        check("no_partial_rsp_after_release", 64'(bus.rsp_valid), 64'd0);
        ready_mode = 0;
        issue(1'b0, BASE + 64'h10, 4'd1, '0, '0);
        drain();

        check("pmem_read_calls", 64'(bus.rd_calls), 64'(exp_rd_calls));
`ifdef DPIC_MEM_WRITE_EN
        check("pmem_write_calls", 64'(bus.wr_calls), 64'(exp_wr_calls));
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
